// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Widths, FSM state encoding, byte-enable constants and the memory command payload.
package mem_arb_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned BE_W         = 4;
    localparam int unsigned LANE_W       = 8;
    localparam int unsigned STARVE_LIMIT = 8;
    localparam int unsigned STARVE_CNT_W = 4;

    localparam logic [BE_W-1:0]   BE_FULL         = 4'hF;
    localparam logic [BE_W-1:0]   BE_NONE         = 4'h0;
    localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              enable;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_cmd_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mem_arb_lane_merge.sv
// Combinational 4-lane byte merge: lanes with be set take new_word, the rest keep old_word.
module mem_arb_lane_merge
    import mem_arb_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] word_c
);

    always_comb begin
        word_c = old_word;
        for (int l = 0; l < BE_W; l++) begin
            if (be[l]) begin
                word_c[l*LANE_W +: LANE_W] = new_word[l*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports; data has priority and
// partial stores run as read-modify-write. MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] merged_word_c;
    logic              latch_en;
    logic              force_fetch;
    mem_cmd_t          cmd;

    mem_arb_lane_merge u_lane_merge (
        .old_word (merge_q),
        .new_word (d_wdata),
        .be       (d_be),
        .word_c   (merged_word_c)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [STARVE_CNT_W-1:0] starve_q;

    // Counts consecutive cycles a fetch request went unacknowledged
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else if (i_req && !i_ack) begin
            starve_q <= starve_q + STARVE_CNT_W'(1);
        end else begin
            starve_q <= '0;
        end
    end

    assign force_fetch = i_req && (starve_q == STARVE_CNT_W'(STARVE_LIMIT));
`else
    assign force_fetch = 1'b0;
`endif

    // State register and RMW word latch; reset drops any half-finished store
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                merge_q <= mem_data_out;
            end
        end
    end

    // Next-state and same-cycle grant/ack decode; everything held low in reset
    always_comb begin
        state_d  = state_q;
        cmd      = '0;
        latch_en = 1'b0;
        i_ack    = 1'b0;
        i_rdata  = '0;
        d_ack    = 1'b0;
        d_rdata  = '0;

        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (d_req && !force_fetch) begin
                        if (!d_wr) begin
                            cmd.enable = 1'b1;
                            cmd.addr   = word_align(d_addr);
                            d_ack      = 1'b1;
                            d_rdata    = mem_data_out;
                        end else if (d_be == BE_FULL) begin
                            cmd.enable = 1'b1;
                            cmd.wr     = 1'b1;
                            cmd.addr   = word_align(d_addr);
                            cmd.data   = d_wdata;
                            d_ack      = 1'b1;
                        end else if (d_be == BE_NONE) begin
                            d_ack = 1'b1;
                        end else begin
                            cmd.enable = 1'b1;
                            cmd.addr   = word_align(d_addr);
                            latch_en   = 1'b1;
                            state_d    = ST_RMW_WR;
                        end
                    end else if (i_req) begin
                        cmd.enable = 1'b1;
                        cmd.addr   = i_addr;
                        i_ack      = 1'b1;
                        i_rdata    = mem_data_out;
                    end
                end
                ST_RMW_WR: begin
                    // A dropped request here is a protocol violation: abandon without writing
                    if (d_req) begin
                        cmd.enable = 1'b1;
                        cmd.wr     = 1'b1;
                        cmd.addr   = word_align(d_addr);
                        cmd.data   = merged_word_c;
                        d_ack      = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign mem_enable  = cmd.enable;
    assign mem_wr      = cmd.wr;
    assign mem_addr    = cmd.addr;
    assign mem_data_in = cmd.data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model and a shadow memory image.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ack;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_enable, mem_wr;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;

    logic        tb_wr_en;
    logic [7:0]  tb_wr_idx;
    logic [31:0] tb_wr_data;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  dphase  = 0;
    int  denied  = 0;
    bit  exp_dack, exp_iack;
    bit  obs_dack, obs_iack;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_be         (d_be),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Memory instance: combinational read, write on posedge; bench preload port
    assign mem_data_out = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_enable && mem_wr) mem[mem_addr[9:2]] <= mem_data_in;
        else if (tb_wr_en)        mem[tb_wr_idx]     <= tb_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] w = old_w;
        for (int l = 0; l < 4; l++) if (be[l]) w[8*l +: 8] = new_w[8*l +: 8];
        return w;
    endfunction

    // Predict this cycle's outcome from the transaction rules, compare, then advance the model
    task automatic cycle_check();
        bit          e_d = 0, e_i = 0, e_en = 0, e_wr = 0, forced = 0;
        logic [31:0] e_drd = '0, e_ird = '0, e_addr = '0, e_din = '0;
        int          widx = -1;
        obs_dack = d_ack;
        obs_iack = i_ack;
        if (rst) begin
            dphase = 0;
            denied = 0;
        end else begin
            forced = GUARD && i_req && dphase == 0 && (denied % 16) == 8;
            if (dphase == 1) begin
                e_d = 1; e_en = 1; e_wr = 1;
                e_addr = d_addr & 32'hFFFF_FFFC;
                e_din  = merge_word(ref_mem[d_addr[9:2]], d_wdata, d_be);
                widx   = int'(d_addr[9:2]);
                dphase = 0;
            end else if (d_req && !forced) begin
                if (!d_wr) begin
                    e_d = 1; e_en = 1;
                    e_addr = d_addr & 32'hFFFF_FFFC;
                    e_drd  = ref_mem[d_addr[9:2]];
                end else if (d_be == 4'hF) begin
                    e_d = 1; e_en = 1; e_wr = 1;
                    e_addr = d_addr & 32'hFFFF_FFFC;
                    e_din  = d_wdata;
                    widx   = int'(d_addr[9:2]);
                end else if (d_be == 4'h0) begin
                    e_d = 1;
                end else begin
                    e_en = 1;
                    e_addr = d_addr & 32'hFFFF_FFFC;
                    dphase = 1;
                end
            end else if (i_req) begin
                e_i = 1; e_en = 1;
                e_addr = i_addr;
                e_ird  = ref_mem[i_addr[9:2]];
            end
            if (i_req && !e_i) denied++;
            else               denied = 0;
        end
        check("d_ack",      32'(d_ack),      32'(e_d));
        check("i_ack",      32'(i_ack),      32'(e_i));
        check("mem_enable", 32'(mem_enable), 32'(e_en));
        check("mem_wr",     32'(mem_wr),     32'(e_wr));
        check("d_rdata",    d_rdata,         e_drd);
        check("i_rdata",    i_rdata,         e_ird);
        if (rst) check("mem_addr_rst", mem_addr, 32'h0);
        if (e_en) check("mem_addr", mem_addr, e_addr);
        if (e_wr) check("mem_data_in", mem_data_in, e_din);
        if (widx >= 0) ref_mem[widx] = e_din;
        exp_dack = e_d;
        exp_iack = e_i;
    endtask

    task automatic tick();
        #1 cycle_check();
        @(posedge clk);
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        i_req = 0; d_req = 0;
        tb_wr_en = 1; tb_wr_idx = 8'(idx); tb_wr_data = val;
        ref_mem[idx] = val;
        tick();
        @(negedge clk);
        tb_wr_en = 0;
    endtask

    initial begin
        int first_iack;
        rst = 1; tb_wr_en = 0; tb_wr_idx = '0; tb_wr_data = '0;
        i_req = 1; i_addr = 32'h10;
        d_req = 1; d_wr = 0; d_addr = 32'h80; d_wdata = '0; d_be = 4'hF;

        // Reset with both requests pending, filling memory meanwhile
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            tb_wr_en = 1; tb_wr_idx = 8'(k); tb_wr_data = $urandom;
            ref_mem[k] = tb_wr_data;
            tick();
        end
        @(negedge clk);
        tb_wr_en = 0; rst = 0;
        tick();
        check("t1_first_dack", 32'(obs_dack), 32'h1);

        // Contention: data load wins, fetch served next cycle
        @(negedge clk);
        i_req = 1; i_addr = 32'h10; d_req = 1; d_wr = 0; d_addr = 32'h20;
        tick();
        check("t2_c0_dack", 32'(obs_dack), 32'h1);
        @(negedge clk);
        d_req = 0;
        tick();
        check("t2_c1_iack", 32'(obs_iack), 32'h1);
        @(negedge clk);
        i_req = 0;
        tick();

        // Byte store via RMW with a concurrent fetch
        preload(16, 32'h1122_3344);
        i_req = 1; i_addr = 32'h100;
        d_req = 1; d_wr = 1; d_addr = 32'h40; d_be = 4'b0010; d_wdata = 32'h0000_AB00;
        tick();
        check("t3_c0_noack", 32'({obs_dack, obs_iack}), 32'h0);
        @(negedge clk);
        tick();
        check("t3_c1_dack", 32'({obs_dack, obs_iack}), 32'h2);
        @(negedge clk);
        d_req = 0;
        tick();
        check("t3_c2_iack", 32'(obs_iack), 32'h1);
        check("t3_word", mem[16], 32'h1122_AB44);
        @(negedge clk);
        i_req = 0;

        // Full-word store, then empty byte-enable store
        d_req = 1; d_wr = 1; d_addr = 32'h44; d_be = 4'hF; d_wdata = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        d_be = 4'h0; d_wdata = 32'h0BAD_F00D;
        tick();
        @(negedge clk);
        d_req = 0;
        tick();
        check("t4_word", mem[17], 32'hDEAD_BEEF);

        // Reset lands on the write half of an RMW
        preload(16, 32'h1122_3344);
        d_req = 1; d_wr = 1; d_addr = 32'h40; d_be = 4'b0010; d_wdata = 32'h0000_AB00;
        tick();
        @(negedge clk);
        rst = 1;
        tick();
        @(negedge clk);
        rst = 0; d_req = 0;
        tick();
        check("t5_word", mem[16], 32'h1122_3344);

        // Continuous data loads against a waiting fetch
        first_iack = -1;
        @(negedge clk);
        i_req = 1; i_addr = 32'h200; d_req = 1; d_wr = 0;
        for (int c = 0; c < 20; c++) begin
            d_addr = 32'($urandom_range(0, 1023));
            if (c > 0) @(negedge clk);
            if (first_iack >= 0) i_req = 0;
            tick();
            if (obs_iack && first_iack < 0) first_iack = c;
        end
        check("t6_first_iack", 32'(first_iack), GUARD ? 32'd8 : 32'hFFFF_FFFF);
        @(negedge clk);
        i_req = 0; d_req = 0;
        tick();

        // Random traffic; requests held until the model says they are acknowledged
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!d_req || exp_dack) begin
                d_req   = ($urandom_range(0, 99) < 60);
                d_wr    = 1'($urandom_range(0, 1));
                d_addr  = 32'($urandom_range(0, 1023));
                d_wdata = $urandom;
                case ($urandom_range(0, 3))
                    0:       d_be = 4'hF;
                    1:       d_be = 4'h0;
                    default: d_be = 4'($urandom_range(0, 15));
                endcase
            end
            if (!i_req || exp_iack) begin
                i_req  = ($urandom_range(0, 99) < 50);
                i_addr = 32'($urandom_range(0, 1023));
            end
            tick();
        end
        @(negedge clk);
        i_req = 0; d_req = 0;
        tick();
        @(negedge clk);
        for (int k = 0; k < 256; k++) check("mem_word", mem[k], ref_mem[k]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
